// File: rtl/dsp_mac_sequencer.sv
// Operand sequencer for a DSP48A1 in multiply-accumulate mode.
// Streams signed operand pairs per block, schedules OPMODE and captures P.
module dsp_mac_sequencer #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned CBITS   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [17:0]       in_a_i,
  input  logic [17:0]       in_b_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [47:0]       res_o,
  output logic [CBITS-1:0]  res_cnt_o,
  output logic              busy_o,
  output logic [17:0]       dsp_a_o,
  output logic [17:0]       dsp_b_o,
  output logic [7:0]        dsp_opmode_o,
  output logic              dsp_ce_o,
  output logic              dsp_rst_o,
  input  logic [47:0]       dsp_p_i
);

  localparam int unsigned NSTG = MUL_LAT + 2;
  localparam int unsigned OPS  = MUL_LAT - 2;
  localparam int unsigned TAGW = 3;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_ACC  = 8'h09;
  localparam logic [7:0] OP_HOLD = 8'h08;

  // Tag bits: [2] valid, [1] first, [0] last
  logic [TAGW-1:0]  tag_q [NSTG];
  logic [TAGW-1:0]  tag_d [NSTG];

  logic [1:0]       state_q, state_d;
  logic             started_q, started_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [47:0]      res_q, res_d;
  logic [CBITS-1:0] res_cnt_q, res_cnt_d;
  logic             busy_q, busy_d;
  logic [17:0]      a_q, a_d;
  logic [17:0]      b_q, b_d;
  logic [7:0]       opmode_q, opmode_d;
  logic             ce_q;
  logic             dsp_rst_q;
  logic             accept_c;
  logic             capture_c;

  assign accept_c  = in_valid_i && in_ready_q && (state_q == ST_ACCUM);
  assign capture_c = tag_q[NSTG-1][2] && tag_q[NSTG-1][0];

  // Next-state, feed stage, tag pipeline and capture
  always_comb begin
    state_d     = state_q;
    started_d   = started_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    res_cnt_d   = res_cnt_q;
    a_d         = 18'd0;
    b_d         = 18'd0;
    tag_d[0]    = '0;
    for (int unsigned i = 1; i < NSTG; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    case (state_q)
      ST_ACCUM: begin
        if (accept_c) begin
          a_d      = in_a_i;
          b_d      = in_b_i;
          tag_d[0] = {1'b1, !started_q, in_last_i};
          cnt_d    = started_q ? cnt_q + CBITS'(1) : CBITS'(1);
          if (in_last_i) begin
            state_d   = ST_DRAIN;
            started_d = 1'b0;
          end else begin
            started_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (capture_c) begin
          res_d       = dsp_p_i;
          res_cnt_d   = cnt_q;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_valid_q && res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    // OPMODE register loads one edge ahead of the DSP OPMODE/M registers
    if (!tag_q[OPS][2]) begin
      opmode_d = OP_HOLD;
    end else if (tag_q[OPS][1]) begin
      opmode_d = OP_LOAD;
    end else begin
      opmode_d = OP_ACC;
    end

    in_ready_d = (state_d == ST_ACCUM);
    busy_d     = (state_d != ST_ACCUM) || started_d;
  end

  always_ff @(posedge clk_i) begin
    dsp_rst_q <= rst_i;
    if (rst_i) begin
      state_q     <= ST_ACCUM;
      started_q   <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_cnt_q   <= '0;
      busy_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      opmode_q    <= OP_HOLD;
      ce_q        <= 1'b0;
      for (int unsigned i = 0; i < NSTG; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      started_q   <= started_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      res_cnt_q   <= res_cnt_d;
      busy_q      <= busy_d;
      a_q         <= a_d;
      b_q         <= b_d;
      opmode_q    <= opmode_d;
      ce_q        <= 1'b1;
      for (int unsigned i = 0; i < NSTG; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign in_ready_o   = in_ready_q;
  assign res_valid_o  = res_valid_q;
  assign res_o        = res_q;
  assign res_cnt_o    = res_cnt_q;
  assign busy_o       = busy_q;
  assign dsp_a_o      = a_q;
  assign dsp_b_o      = b_q;
  assign dsp_opmode_o = opmode_q;
  assign dsp_ce_o     = ce_q;
  assign dsp_rst_o    = dsp_rst_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 MAC model.
module tb_dsp_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [17:0] in_a = '0;
  logic [17:0] in_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [47:0] res;
  logic [9:0]  res_cnt;
  logic        busy;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce, dsp_rst;
  logic [47:0] dsp_p;

  int n_checks = 0;
  int n_errors = 0;

  dsp_mac_sequencer #(.MUL_LAT(3), .CBITS(10)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last),
    .in_a_i(in_a), .in_b_i(in_b),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_o(res), .res_cnt_o(res_cnt), .busy_o(busy),
    .dsp_a_o(dsp_a), .dsp_b_o(dsp_b), .dsp_opmode_o(dsp_opmode),
    .dsp_ce_o(dsp_ce), .dsp_rst_o(dsp_rst), .dsp_p_i(dsp_p)
  );

  always #5 clk = ~clk;

  // DSP48A1 with A0/A1/B0/B1/M/P/OPMODE registers, pre-adder bypassed
  logic signed [17:0] a0, a1, b0, b1;
  logic signed [35:0] m_r;
  logic signed [47:0] p_r;
  logic        [7:0]  op_r;
  logic signed [47:0] x_sel, z_sel;
  assign x_sel = (op_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'sd0;
  assign z_sel = (op_r[3:2] == 2'b10) ? p_r : 48'sd0;
  assign dsp_p = p_r;

  always @(posedge clk) begin
    if (dsp_rst) begin
      a0 <= '0; a1 <= '0; b0 <= '0; b1 <= '0;
      m_r <= '0; p_r <= '0; op_r <= '0;
    end else if (dsp_ce) begin
      a0 <= dsp_a; a1 <= a0;
      b0 <= dsp_b; b1 <= b0;
      m_r <= a1 * b1;
      op_r <= dsp_opmode;
      p_r <= z_sel + x_sel;
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready", longint'(in_ready), 1);
    @(posedge clk);
  endtask

  // Returns cycles from the accepting edge until res_valid is seen (-1 on timeout)
  task automatic wait_result(input logic early, output int lat);
    lat = -1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; res_ready = early;
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge clk);
      if (res_valid) begin
        lat = j;
        break;
      end
    end
    check_eq("res_seen", longint'(res_valid), 1);
  endtask

  task automatic handoff();
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("hand_valid", longint'(res_valid), 0);
    check_eq("hand_ready", longint'(in_ready), 1);
    res_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [47:0] held;
    logic [17:0] ga [3];
    logic [17:0] gb [3];
    longint exp_op;
    ga[0] = 18'd3; ga[1] = 18'd5;          ga[2] = 18'(-7);
    gb[0] = 18'd4; gb[1] = 18'(-6);        gb[2] = 18'd8;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", longint'(in_ready), 0);
    check_eq("rst_res_valid", longint'(res_valid), 0);
    check_eq("rst_res", longint'(res), 0);
    check_eq("rst_res_cnt", longint'(res_cnt), 0);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_dsp_a", longint'(dsp_a), 0);
    check_eq("rst_dsp_b", longint'(dsp_b), 0);
    check_eq("rst_opmode", longint'(dsp_opmode), 8);
    check_eq("rst_ce", longint'(dsp_ce), 0);
    check_eq("rst_dsp_rst", longint'(dsp_rst), 1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", longint'(in_ready), 1);
    check_eq("post_rst_ce", longint'(dsp_ce), 1);
    check_eq("post_rst_dsp_rst", longint'(dsp_rst), 0);

    // Back-to-back three-term block
    send(18'd3, 18'd4, 1'b0);
    send(18'd5, 18'(-6), 1'b0);
    send(18'(-7), 18'd8, 1'b1);
    wait_result(1'b0, lat);
    check_eq("b2b_latency", longint'(lat), 5);
    check_eq("b2b_res", $signed(res), -74);
    check_eq("b2b_cnt", longint'(res_cnt), 3);
    check_eq("b2b_busy", longint'(busy), 1);
    handoff();

    // Same block with two idle cycles between pairs; OPMODE follows accepts by 2 edges
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) begin
        @(negedge clk);
        exp_op = (i - 1 == 2) ? 1 : ((i - 1 == 5 || i - 1 == 8) ? 9 : 8);
        check_eq("gap_opmode", longint'(dsp_opmode), exp_op);
      end
      if (i == 11) check_eq("gap_early_valid", longint'(res_valid), 0);
      in_valid = (i % 3 == 0) && (i <= 6);
      in_a = ga[(i / 3) % 3];
      in_b = gb[(i / 3) % 3];
      in_last = (i == 6);
    end
    check_eq("gap_valid", longint'(res_valid), 1);
    check_eq("gap_res", $signed(res), -74);
    check_eq("gap_cnt", longint'(res_cnt), 3);
    handoff();

    // Single most-negative pair
    send(18'h20000, 18'h20000, 1'b1);
    wait_result(1'b0, lat);
    check_eq("single_latency", longint'(lat), 5);
    check_eq("single_res", $signed(res), 64'sd17179869184);
    check_eq("single_cnt", longint'(res_cnt), 1);

    // Downstream stalls; a pending pair must not be taken
    held = res;
    in_valid = 1'b1; in_a = 18'd1; in_b = 18'd1; in_last = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_eq("stall_valid", longint'(res_valid), 1);
      check_eq("stall_res", longint'(res), longint'(held));
      check_eq("stall_in_ready", longint'(in_ready), 0);
      check_eq("stall_busy", longint'(busy), 1);
    end
    res_ready = 1'b1;
    send(18'd1, 18'd1, 1'b1);
    wait_result(1'b0, lat);
    check_eq("after_stall_res", $signed(res), 1);
    check_eq("after_stall_cnt", longint'(res_cnt), 1);
    handoff();

    // 1030 terms: counter wraps, sum stays exact
    for (int i = 0; i < 1030; i++) send(18'd131071, 18'd131071, i == 1029);
    wait_result(1'b0, lat);
    check_eq("wrap_res", $signed(res), 64'sd1030 * 64'sd131071 * 64'sd131071);
    check_eq("wrap_cnt", longint'(res_cnt), 6);
    handoff();

    // Reset midway through a four-term block
    send(18'd1, 18'd2, 1'b0);
    send(18'd3, 18'd4, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_eq("abort_no_valid", longint'(res_valid), 0);
    end
    check_eq("abort_busy", longint'(busy), 0);
    send(18'd2, 18'd2, 1'b1);
    wait_result(1'b1, lat);
    check_eq("abort_latency", longint'(lat), 5);
    check_eq("abort_res", $signed(res), 4);
    check_eq("abort_cnt", longint'(res_cnt), 1);
    @(negedge clk);
    check_eq("early_valid", longint'(res_valid), 0);
    check_eq("early_in_ready", longint'(in_ready), 1);
    res_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
